// File: rtl/bus_mem_slave.sv
// Word-wide RAM slave for the CPU bus: accepts Cs_/As_ requests, stalls WAIT_CYCLES, then pulses Rdy_.
// Optional write protection (WrProt/WrErr ports) is enabled by defining BUS_MEM_SLAVE_WRPROT_EN.
module bus_mem_slave #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 1,
  localparam int unsigned AddrW      = 30,
  localparam int unsigned DataW      = 32
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             Cs_,
  input  logic             As_,
  input  logic             RW,
  input  logic [AddrW-1:0] Addr,
  input  logic [DataW-1:0] WrData,
  output logic [DataW-1:0] RdData,
  output logic             Rdy_
`ifdef BUS_MEM_SLAVE_WRPROT_EN
  ,
  input  logic             WrProt,
  output logic             WrErr
`endif
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned CntW  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  rw_q, rw_d;
  logic [DataW-1:0]      wdata_q, wdata_d;
  logic                  prot_q, prot_d;
  logic                  rdy_q, rdy_d;
  logic [DataW-1:0]      rdata_q, rdata_d;
  logic                  mem_we_c;
  logic                  wr_prot_c;
  logic [DataW-1:0]      mem_q [Depth];

  // Upper address bits alias onto the array and are intentionally dropped.
  logic                  unused_addr_c;
  assign unused_addr_c = ^Addr[AddrW-1:DEPTH_LOG2];

`ifdef BUS_MEM_SLAVE_WRPROT_EN
  logic werr_q, werr_d;
  assign wr_prot_c = WrProt;
  assign WrErr     = werr_q;
`else
  assign wr_prot_c = 1'b0;
`endif

  assign RdData = rdata_q;
  assign Rdy_   = rdy_q;

  // Next-state and registered-output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    rw_d     = rw_q;
    wdata_d  = wdata_q;
    prot_d   = prot_q;
    rdy_d    = 1'b1;
    rdata_d  = '0;
    mem_we_c = 1'b0;
`ifdef BUS_MEM_SLAVE_WRPROT_EN
    werr_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!Cs_ && !As_) begin
          idx_d   = Addr[DEPTH_LOG2-1:0];
          rw_d    = RW;
          wdata_d = WrData;
          prot_d  = wr_prot_c;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CntW'(WAIT_CYCLES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (Cs_ || As_) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        rdy_d   = 1'b0;
        if (rw_q) begin
          rdata_d = mem_q[idx_q];
        end else begin
          mem_we_c = !prot_q;
`ifdef BUS_MEM_SLAVE_WRPROT_EN
          werr_d   = prot_q;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      prot_q  <= 1'b0;
      rdy_q   <= 1'b1;
      rdata_q <= '0;
`ifdef BUS_MEM_SLAVE_WRPROT_EN
      werr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      prot_q  <= prot_d;
      rdy_q   <= rdy_d;
      rdata_q <= rdata_d;
`ifdef BUS_MEM_SLAVE_WRPROT_EN
      werr_q  <= werr_d;
`endif
    end
  end

  // Storage is not reset; contents survive reset_.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

endmodule
